timer_device: RTL and testbench

TIMER_DEVICE -- requirements
Module: timer_device

---
 rtl/timer_device_pkg.sv | 29 ++
 rtl/timer_device.sv | 100 ++++++++++
 tb/tb_timer_device.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_device_pkg.sv
// rtl/timer_device_pkg.sv - shared FSM encoding, register map and CTRL field layout for timer_device
`timescale 1ns/1ps
package timer_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Reserved mode codes (1x) fold onto one-shot.
  function automatic logic [1:0] mode_eff(input logic [1:0] mode);
    return (mode == MODE_AUTO) ? MODE_AUTO : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_device.sv
// rtl/timer_device.sv - programmable down-counter timer with one-shot/auto-reload modes and masked IRQ
`timescale 1ns/1ps
module timer_device
  import timer_device_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        Write_Enabled,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        IRQ
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic wr_ctrl, wr_preset, unmask;

  assign wr_ctrl   = Write_Enabled && (Addr == ADDR_CTRL);
  assign wr_preset = Write_Enabled && (Addr == ADDR_PRESET);
  // Turning IM on is how software unmasks a latched interrupt, so it must not acknowledge it.
  assign unmask    = wr_ctrl && !ctrl_q[CTRL_IM] && Data_In[CTRL_IM];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (wr_preset) preset_d = Data_In;
    if ((wr_ctrl && !unmask) || wr_preset) pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = 32'd0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (mode_eff(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]) == MODE_AUTO) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so a software CTRL write overrides the hardware Enable clear.
    if (wr_ctrl) ctrl_d = Data_In[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   Data_Out = {28'd0, ctrl_q};
      ADDR_PRESET: Data_Out = preset_q;
      ADDR_COUNT:  Data_Out = count_q;
      default:     Data_Out = 32'd0;
    endcase
  end

  assign IRQ = pend_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - self-checking bench for timer_device: register table, directed corner cases, randomized timeline model
`timescale 1ns/1ps
module tb_timer_device;

  logic        clk;
  logic        rst;
  logic [1:0]  Addr;
  logic        Write_Enabled;
  logic [31:0] Data_In;
  logic [31:0] Data_Out;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  timer_device dut (
    .clk           (clk),
    .rst           (rst),
    .Addr          (Addr),
    .Write_Enabled (Write_Enabled),
    .Data_In       (Data_In),
    .Data_Out      (Data_Out),
    .IRQ           (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    Write_Enabled = 1'b1;
    Addr          = a;
    Data_In       = d;
    tick();
    Write_Enabled = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, Data_Out, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_0000};
    vecs[3]  = '{1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_0000};
    vecs[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFE, 2'd0, 32'h0000_000E};
    vecs[5]  = '{1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_1234, 2'd2, 32'h0000_0000};
    vecs[7]  = '{1'b1, 2'd3, 32'h0000_5555, 2'd3, 32'h0000_0000};
    vecs[8]  = '{1'b1, 2'd3, 32'h0000_0000, 2'd1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 2'd0, 32'h0000_0006, 2'd0, 32'h0000_0006};
    vecs[10] = '{1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};
    vecs[11] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};

    rst           = 1'b0;
    Write_Enabled = 1'b0;
    Addr          = 2'd0;
    Data_In       = 32'd0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // Register map table
    for (int i = 0; i < 12; i++) begin
      Write_Enabled = vecs[i].we;
      Addr          = vecs[i].wa;
      Data_In       = vecs[i].wd;
      tick();
      Write_Enabled = 1'b0;
      Addr          = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_data", i), Data_Out, vecs[i].exp);
      chk($sformatf("vec%0d_irq", i), 32'(IRQ), 32'd0);
    end

    // One-shot: PRESET=5, CTRL=0x9
    bus_wr(2'd1, 32'd5);
    bus_wr(2'd0, 32'h9);
    Addr = 2'd2;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("os_irq_k%0d", k), 32'(IRQ), 32'(k >= 7));
      if (k >= 2) chk($sformatf("os_count_k%0d", k), Data_Out, 32'((k - 2 < 5) ? 5 - (k - 2) : 0));
    end
    chk_rd("os_ctrl_readback", 2'd0, 32'h8);
    bus_wr(2'd0, 32'h8);
    chk("os_ack_irq", 32'(IRQ), 32'd0);

    // Auto-reload: PRESET=3, CTRL=0xB
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'hB);
    Addr = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("ar_irq_k%0d", k), 32'(IRQ), 32'(k >= 5 && (k - 5) % 5 == 0));
      if (k >= 2) chk($sformatf("ar_count_k%0d", k), Data_Out,
                      32'((((k - 2) % 5) < 3) ? 3 - ((k - 2) % 5) : 0));
    end
    bus_wr(2'd0, 32'h0);
    repeat (3) tick();

    // Masked: PRESET=2, CTRL=0x1, then unmask
    bus_wr(2'd1, 32'd2);
    bus_wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("mask_irq_k%0d", k), 32'(IRQ), 32'd0);
    end
    chk_rd("mask_ctrl_readback", 2'd0, 32'h0);
    bus_wr(2'd0, 32'h8);
    chk("unmask_irq", 32'(IRQ), 32'd1);
    tick();
    chk("unmask_irq_held", 32'(IRQ), 32'd1);
    bus_wr(2'd0, 32'h8);
    chk("unmask_ack_irq", 32'(IRQ), 32'd0);
    bus_wr(2'd0, 32'h0);

    // Pause and resume: PRESET=10
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'h1);
    Addr = 2'd2;
    repeat (7) tick();
    chk("pause_count_pre", Data_Out, 32'd5);
    bus_wr(2'd0, 32'h0);
    chk_rd("pause_count_at_write", 2'd2, 32'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("pause_frozen_%0d", k), Data_Out, 32'd4);
    end
    bus_wr(2'd0, 32'h1);
    chk_rd("resume_edge", 2'd2, 32'd4);
    tick();
    chk("resume_load_edge", Data_Out, 32'd4);
    tick();
    chk("resume_reload", Data_Out, 32'd10);
    tick();
    chk("resume_dec", Data_Out, 32'd9);
    bus_wr(2'd0, 32'h0);
    repeat (3) tick();

    // Collision: PRESET write on the INT-entry edge, then PRESET=0 timing
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'h9);
    repeat (4) tick();
    chk("coll_irq_before", 32'(IRQ), 32'd0);
    bus_wr(2'd1, 32'd0);
    chk("coll_irq_set_wins", 32'(IRQ), 32'd1);
    tick();
    chk("coll_irq_held", 32'(IRQ), 32'd1);
    bus_wr(2'd0, 32'h8);
    chk("coll_ack", 32'(IRQ), 32'd0);
    bus_wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("p0_irq_k%0d", k), 32'(IRQ), 32'(k >= 3));
    end
    bus_wr(2'd0, 32'h0);
    repeat (3) tick();

    // Randomized trials against a closed-form timeline model
    for (int t = 0; t < 20; t++) begin
      int p, pe, mode, im, len, d, r, cnt;
      logic pend;
      logic [3:0] c;
      p    = int'($urandom_range(0, 12));
      pe   = (p == 0) ? 1 : p;
      mode = int'($urandom_range(0, 3));
      im   = int'($urandom_range(0, 1));
      c    = {im[0], mode[1:0], 1'b1};
      bus_wr(2'd1, 32'(p));
      bus_wr(2'd0, {28'd0, c});
      Addr = 2'd2;
      len  = 3 * (pe + 2) + 2;
      for (int k = 1; k <= len; k++) begin
        tick();
        d    = k - 2;
        pend = 1'b0;
        if (d >= 0) begin
          r    = (mode == 1) ? d % (pe + 2) : d;
          cnt  = (r < pe) ? p - r : 0;
          pend = (mode == 1) ? (r == pe) : (r >= pe);
          chk($sformatf("rnd%0d_count_k%0d", t, k), Data_Out, 32'(cnt));
        end
        chk($sformatf("rnd%0d_irq_k%0d", t, k), 32'(IRQ), 32'(pend & im[0]));
      end
      chk_rd($sformatf("rnd%0d_ctrl", t), 2'd0, {28'd0, (mode == 1) ? c : (c & 4'hE)});
      bus_wr(2'd0, 32'h0);
      repeat (3) tick();
    end

    // Asynchronous reset mid-count
    bus_wr(2'd1, 32'd20);
    bus_wr(2'd0, 32'h9);
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk($sformatf("post_rst_irq_%0d", k), 32'(IRQ), 32'd0);
      chk($sformatf("post_rst_count_%0d", k), Data_Out, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
